// File: rtl/rvx_core_store_unit.sv
// Store formatter and memory write-port sequencer: aligns address, replicates/positions data, builds strobes.
// Build option RVX_MISALIGNED_STORE_EN: split misaligned stores into two bus beats instead of rejecting them.
module rvx_core_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        store_request,
    input  logic [1:0]  store_size,
    input  logic [31:0] store_address,
    input  logic [31:0] store_data,
    output logic        store_busy,
    output logic        store_done,
    output logic        store_misaligned,
    output logic [31:0] memory_address_rw,
    output logic        memory_write_request,
    output logic [31:0] memory_write_data,
    output logic [3:0]  memory_write_strobe,
    input  logic        memory_write_response
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WRITE_LO = 2'b01,
        WRITE_HI = 2'b10
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   lane_replicate = {4{data[7:0]}};
            2'b01:   lane_replicate = {2{data[15:0]}};
            default: lane_replicate = data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    state_t      state_r, state_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        misaligned_r, misaligned_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] data_r, data_s;
    logic [3:0]  strobe_r, strobe_s;

    logic [3:0]  mask_s;
    logic [1:0]  off_s;
    logic [31:0] repl_s;
    logic [3:0]  strobe_lo_s;
    logic        misaligned_cmd_s;

    assign mask_s           = size_mask(store_size);
    assign off_s            = store_address[1:0];
    assign repl_s           = lane_replicate(store_size, store_data);
    assign strobe_lo_s      = mask_s << off_s;
    assign misaligned_cmd_s = is_misaligned(store_size, off_s);

`ifdef RVX_MISALIGNED_STORE_EN
    logic [63:0] shifted_s;
    logic [7:0]  strobe_wide_s;
    logic [31:0] hi_data_r, hi_data_s;
    logic [3:0]  hi_strobe_r, hi_strobe_s;

    assign shifted_s     = {32'h0000_0000, repl_s} << {off_s, 3'b000};
    assign strobe_wide_s = {4'b0000, mask_s} << off_s;
`endif

    // Next-state and next-output logic for the store sequencer
    always_comb begin
        state_s      = state_r;
        req_s        = req_r;
        addr_s       = addr_r;
        data_s       = data_r;
        strobe_s     = strobe_r;
        done_s       = 1'b0;
        misaligned_s = 1'b0;
`ifdef RVX_MISALIGNED_STORE_EN
        hi_data_s    = hi_data_r;
        hi_strobe_s  = hi_strobe_r;
`endif
        case (state_r)
            IDLE: begin
                if (store_request) begin
                    if (!misaligned_cmd_s) begin
                        // Replicated data matches the shifted data in every strobed lane
                        state_s  = WRITE_LO;
                        req_s    = 1'b1;
                        addr_s   = {store_address[31:2], 2'b00};
                        data_s   = repl_s;
                        strobe_s = strobe_lo_s;
`ifdef RVX_MISALIGNED_STORE_EN
                        hi_data_s   = 32'h0000_0000;
                        hi_strobe_s = 4'b0000;
`endif
                    end else begin
`ifdef RVX_MISALIGNED_STORE_EN
                        state_s     = WRITE_LO;
                        req_s       = 1'b1;
                        addr_s      = {store_address[31:2], 2'b00};
                        data_s      = shifted_s[31:0];
                        strobe_s    = strobe_wide_s[3:0];
                        hi_data_s   = shifted_s[63:32];
                        hi_strobe_s = strobe_wide_s[7:4];
`else
                        misaligned_s = 1'b1;
`endif
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE_LO: begin
                if (memory_write_response) begin
`ifdef RVX_MISALIGNED_STORE_EN
                    if (hi_strobe_r != 4'b0000) begin
                        state_s  = WRITE_HI;
                        addr_s   = addr_r + 32'd4;
                        data_s   = hi_data_r;
                        strobe_s = hi_strobe_r;
                    end else begin
                        state_s = IDLE;
                        req_s   = 1'b0;
                        done_s  = 1'b1;
                    end
`else
                    state_s = IDLE;
                    req_s   = 1'b0;
                    done_s  = 1'b1;
`endif
                end else begin
                    state_s = WRITE_LO;
                end
            end
`ifdef RVX_MISALIGNED_STORE_EN
            WRITE_HI: begin
                if (memory_write_response) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = WRITE_HI;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            req_r        <= 1'b0;
            addr_r       <= 32'h0000_0000;
            data_r       <= 32'h0000_0000;
            strobe_r     <= 4'b0000;
`ifdef RVX_MISALIGNED_STORE_EN
            hi_data_r    <= 32'h0000_0000;
            hi_strobe_r  <= 4'b0000;
`endif
        end else begin
            state_r      <= state_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            misaligned_r <= misaligned_s;
            req_r        <= req_s;
            addr_r       <= addr_s;
            data_r       <= data_s;
            strobe_r     <= strobe_s;
`ifdef RVX_MISALIGNED_STORE_EN
            hi_data_r    <= hi_data_s;
            hi_strobe_r  <= hi_strobe_s;
`endif
        end
    end

    assign store_busy           = busy_r;
    assign store_done           = done_r;
    assign store_misaligned     = misaligned_r;
    assign memory_address_rw    = addr_r;
    assign memory_write_request = req_r;
    assign memory_write_data    = data_r;
    assign memory_write_strobe  = strobe_r;

endmodule

// File: tb/tb_rvx_core_store_unit.sv
// Table-driven bench for rvx_core_store_unit with a beat scoreboard; expectations follow RVX_MISALIGNED_STORE_EN.
module tb_rvx_core_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        store_request;
    logic [1:0]  store_size;
    logic [31:0] store_address;
    logic [31:0] store_data;
    logic        store_busy;
    logic        store_done;
    logic        store_misaligned;
    logic [31:0] memory_address_rw;
    logic        memory_write_request;
    logic [31:0] memory_write_data;
    logic [3:0]  memory_write_strobe;
    logic        memory_write_response;

    int total = 0;
    int bad   = 0;

    rvx_core_store_unit dut (
        .clock                 (clock),
        .reset                 (reset),
        .store_request         (store_request),
        .store_size            (store_size),
        .store_address         (store_address),
        .store_data            (store_data),
        .store_busy            (store_busy),
        .store_done            (store_done),
        .store_misaligned      (store_misaligned),
        .memory_address_rw     (memory_address_rw),
        .memory_write_request  (memory_write_request),
        .memory_write_data     (memory_write_data),
        .memory_write_strobe   (memory_write_strobe),
        .memory_write_response (memory_write_response)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic        mis;
        logic        has_hi;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic [31:0] a1, d1;
        logic [3:0]  s1;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                                    input int waits, input logic mis, input logic has_hi,
                                    input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                                    input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
        vec_t v;
        v.size = size; v.addr = addr; v.data = data; v.waits = waits; v.mis = mis; v.has_hi = has_hi;
        v.a0 = a0; v.d0 = d0; v.s0 = s0; v.a1 = a1; v.d1 = d1; v.s1 = s1;
        vecs.push_back(v);
    endfunction

    // Starts and ends just after a falling edge; drives one command and follows it to completion.
    task automatic run_vec(input vec_t v, input int idx);
        beat_t b;
        int    waits_left;
        bit    fin;
        store_request         = 1'b1;
        store_size            = v.size;
        store_address         = v.addr;
        store_data            = v.data;
        memory_write_response = 1'b0;
        if (!v.mis) begin
            b.a = v.a0; b.d = v.d0; b.s = v.s0; sb.push_back(b);
            if (v.has_hi) begin
                b.a = v.a1; b.d = v.d1; b.s = v.s1; sb.push_back(b);
            end
        end
        @(posedge clock); @(negedge clock);
        store_request = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d_mis_pulse", idx), {31'd0, store_misaligned}, 32'd1);
            chk($sformatf("v%0d_mis_req", idx), {31'd0, memory_write_request}, 32'd0);
            chk($sformatf("v%0d_mis_busy", idx), {31'd0, store_busy}, 32'd0);
            chk($sformatf("v%0d_mis_done", idx), {31'd0, store_done}, 32'd0);
            @(posedge clock); @(negedge clock);
            chk($sformatf("v%0d_mis_drop", idx), {31'd0, store_misaligned}, 32'd0);
            chk($sformatf("v%0d_mis_req2", idx), {31'd0, memory_write_request}, 32'd0);
            return;
        end
        waits_left = v.waits;
        fin = 1'b0;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_done", idx), {31'd0, store_done}, 32'd1);
                chk($sformatf("v%0d_busy_end", idx), {31'd0, store_busy}, 32'd0);
                chk($sformatf("v%0d_req_end", idx), {31'd0, memory_write_request}, 32'd0);
                chk($sformatf("v%0d_mis_end", idx), {31'd0, store_misaligned}, 32'd0);
                memory_write_response = 1'b0;
                fin = 1'b1;
            end else begin
                b = sb[0];
                chk($sformatf("v%0d_busy", idx), {31'd0, store_busy}, 32'd1);
                chk($sformatf("v%0d_early_done", idx), {31'd0, store_done}, 32'd0);
                chk($sformatf("v%0d_spurious_mis", idx), {31'd0, store_misaligned}, 32'd0);
                chk($sformatf("v%0d_req", idx), {31'd0, memory_write_request}, 32'd1);
                chk($sformatf("v%0d_addr", idx), memory_address_rw, b.a);
                chk($sformatf("v%0d_data", idx), memory_write_data, b.d);
                chk($sformatf("v%0d_strobe", idx), {28'd0, memory_write_strobe}, {28'd0, b.s});
                if (waits_left > 0) begin
                    memory_write_response = 1'b0;
                    waits_left--;
                end else begin
                    memory_write_response = 1'b1;
                    void'(sb.pop_front());
                    waits_left = v.waits;
                end
                @(posedge clock); @(negedge clock);
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL v%0d_timeout actual=no_done expected=done_within_40_cycles", idx);
            sb.delete();
            memory_write_response = 1'b0;
        end
    endtask

    initial begin
        reset                 = 1'b1;
        store_request         = 1'b0;
        store_size            = 2'b00;
        store_address         = 32'h0000_0000;
        store_data            = 32'h0000_0000;
        memory_write_response = 1'b0;

        add_vec(2'b00, 32'h0000_1003, 32'h0000_00AB, 0, 1'b0, 1'b0,
                32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b01, 32'h0000_2002, 32'h1234_BEEF, 0, 1'b0, 1'b0,
                32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 3, 1'b0, 1'b0,
                32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b00, 32'h0000_5000, 32'hFFFF_FF5A, 1, 1'b0, 1'b0,
                32'h0000_5000, 32'h5A5A_5A5A, 4'b0001, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b11, 32'h0000_6004, 32'hCAFE_F00D, 0, 1'b0, 1'b0,
                32'h0000_6004, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'h0, 4'b0000);
`ifdef RVX_MISALIGNED_STORE_EN
        add_vec(2'b10, 32'h0000_4001, 32'h1122_3344, 0, 1'b0, 1'b1,
                32'h0000_4000, 32'h2233_4400, 4'b1110, 32'h0000_4004, 32'h0000_0011, 4'b0001);
        add_vec(2'b01, 32'h0000_7001, 32'h0000_A55A, 0, 1'b0, 1'b0,
                32'h0000_7000, 32'h5AA5_5A00, 4'b0110, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b10, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0, 1'b0, 1'b1,
                32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100, 32'h0000_0000, 32'h0000_A1B2, 4'b0011);
        add_vec(2'b01, 32'h0000_8003, 32'h0000_7788, 2, 1'b0, 1'b1,
                32'h0000_8000, 32'h8800_0000, 4'b1000, 32'h0000_8004, 32'h0077_8877, 4'b0001);
`else
        add_vec(2'b10, 32'h0000_4001, 32'h1122_3344, 0, 1'b1, 1'b0,
                32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b01, 32'h0000_7001, 32'h0000_A55A, 0, 1'b1, 1'b0,
                32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b10, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0, 1'b1, 1'b0,
                32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
        add_vec(2'b01, 32'h0000_8003, 32'h0000_7788, 2, 1'b1, 1'b0,
                32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
`endif

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", {31'd0, store_busy}, 32'd0);
        chk("rst_done", {31'd0, store_done}, 32'd0);
        chk("rst_mis", {31'd0, store_misaligned}, 32'd0);
        chk("rst_req", {31'd0, memory_write_request}, 32'd0);
        chk("rst_addr", memory_address_rw, 32'h0000_0000);
        chk("rst_data", memory_write_data, 32'h0000_0000);
        chk("rst_strobe", {28'd0, memory_write_strobe}, 32'd0);
        reset = 1'b0;
        @(posedge clock); @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during a WRITE_LO wait, with a stray request ignored while busy
        store_request = 1'b1; store_size = 2'b10;
        store_address = 32'h0000_B000; store_data = 32'h55AA_55AA;
        memory_write_response = 1'b0;
        @(posedge clock); @(negedge clock);
        store_request = 1'b1; store_size = 2'b00;
        store_address = 32'h0000_C001; store_data = 32'h0000_0077;
        chk("hold_req", {31'd0, memory_write_request}, 32'd1);
        chk("hold_addr", memory_address_rw, 32'h0000_B000);
        @(posedge clock); @(negedge clock);
        store_request = 1'b0;
        chk("stray_addr", memory_address_rw, 32'h0000_B000);
        chk("stray_data", memory_write_data, 32'h55AA_55AA);
        chk("stray_strobe", {28'd0, memory_write_strobe}, 32'h0000_000F);
        chk("stray_busy", {31'd0, store_busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        chk("midrst_req", {31'd0, memory_write_request}, 32'd0);
        chk("midrst_busy", {31'd0, store_busy}, 32'd0);
        chk("midrst_done", {31'd0, store_done}, 32'd0);
        chk("midrst_addr", memory_address_rw, 32'h0000_0000);
        chk("midrst_strobe", {28'd0, memory_write_strobe}, 32'd0);
        @(posedge clock); @(negedge clock);
        chk("midrst_done2", {31'd0, store_done}, 32'd0);
        chk("midrst_busy2", {31'd0, store_busy}, 32'd0);
        chk("midrst_req2", {31'd0, memory_write_request}, 32'd0);

        run_vec(vecs[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
